// File: rtl/ps2_dev_pkg.sv
// Shared definitions for the PS/2 device-side transmitter.
package ps2_dev_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BIT_HI,
        ST_BIT_LO,
        ST_HOLD,
        ST_GAP
    } state_e;

    localparam int         FRAME_BITS = 11;
    localparam logic [3:0] STOP_IDX   = 4'(FRAME_BITS - 1);

    // Parity bit that makes data plus parity carry an odd number of ones.
    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

    // Frame as shifted out from bit 0: start, data LSB first, parity, stop.
    function automatic logic [FRAME_BITS-1:0] make_frame(input logic [7:0] b);
        return {1'b1, odd_parity(b), b, 1'b0};
    endfunction

endpackage

// File: rtl/ps2_tx_fifo.sv
// Small synchronous byte FIFO; push is refused while full, read data is
// presented combinationally from the head entry.
module ps2_tx_fifo
    import ps2_dev_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int LW    = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [LW-1:0]    level_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]    cnt_q;
    logic             do_push, do_pop;

    assign full_o  = (cnt_q == LW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    // Push is judged against fullness before any same-cycle pop.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign dout_o  = mem_q[rd_ptr_q];
    assign level_o = cnt_q;

    // Storage writes; contents need no reset since the count guards reads.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

    // Pointers and occupancy; pointers wrap naturally (DEPTH is a power of two).
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/ps2_dev_tx.sv
// PS/2 device-side transmitter: queues bytes and serializes each as an
// 11-bit device-to-host frame, with host-inhibit abort and retransmit.
module ps2_dev_tx
    import ps2_dev_pkg::*;
#(
    parameter int HALF_PERIOD = 2000,
    parameter int GAP_CYCLES  = 4000,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [7:0]                   data_i,
    input  logic                         valid_i,
    output logic                         ready_o,
    input  logic                         inhibit_i,
    output logic                         ps2_clk_o,
    output logic                         ps2_dat_o,
    output logic                         busy_o,
    output logic                         done_o,
    output logic [$clog2(FIFO_DEPTH):0]  level_o
);
    localparam int LW   = $clog2(FIFO_DEPTH) + 1;
    localparam int MAXC = (HALF_PERIOD > GAP_CYCLES) ? HALF_PERIOD : GAP_CYCLES;
    localparam int DW   = $clog2(MAXC);
    localparam logic [DW-1:0] HP_LAST  = DW'(HALF_PERIOD - 1);
    localparam logic [DW-1:0] GAP_LAST = DW'(GAP_CYCLES - 1);

    state_e                  state_q;
    logic [DW-1:0]           div_q;
    logic [3:0]              bit_idx_q;
    logic [FRAME_BITS-1:0]   frame_q;
    logic                    retry_q;
    logic                    clk_q, dat_q, busy_q, done_q;

    logic [7:0]              fifo_dout;
    logic                    fifo_full, fifo_empty, fifo_pop;
    logic                    start_ok, launch, abort, half_end;

    ps2_tx_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH), .LW(LW)) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (valid_i),
        .din_i   (data_i),
        .pop_i   (fifo_pop),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (level_o)
    );

    assign ready_o   = !fifo_full;
    assign ps2_clk_o = clk_q;
    assign ps2_dat_o = dat_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;

    // Start decisions: a frame may start from IDLE or straight out of the last
    // gap cycle, so the line stays high for exactly GAP_CYCLES between frames.
    always_comb begin
        start_ok = !inhibit_i && (retry_q || !fifo_empty);
        launch   = start_ok && ((state_q == ST_IDLE) ||
                                (state_q == ST_GAP && div_q == GAP_LAST));
        fifo_pop = launch && !retry_q;
        abort    = inhibit_i && (bit_idx_q != STOP_IDX) &&
                   (state_q == ST_BIT_HI || state_q == ST_BIT_LO);
        half_end = (div_q == HP_LAST);
    end

    // Frame FSM with registered line outputs; div_q reloads on every transition.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            div_q     <= '0;
            bit_idx_q <= '0;
            frame_q   <= '1;
            retry_q   <= 1'b0;
            clk_q     <= 1'b1;
            dat_q     <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            div_q  <= div_q + 1'b1;
            if (launch) begin
                // A retry re-sends the retained frame without touching the FIFO.
                if (!retry_q) frame_q <= make_frame(fifo_dout);
                retry_q   <= 1'b0;
                bit_idx_q <= '0;
                state_q   <= ST_BIT_HI;
                div_q     <= '0;
                clk_q     <= 1'b1;
                dat_q     <= 1'b0;
                busy_q    <= 1'b1;
            end else if (abort) begin
                state_q <= ST_HOLD;
                div_q   <= '0;
                clk_q   <= 1'b1;
                dat_q   <= 1'b1;
                retry_q <= 1'b1;
            end else begin
                case (state_q)
                    ST_BIT_HI: if (half_end) begin
                        state_q <= ST_BIT_LO;
                        div_q   <= '0;
                        clk_q   <= 1'b0;
                    end
                    ST_BIT_LO: if (half_end) begin
                        div_q <= '0;
                        clk_q <= 1'b1;
                        if (bit_idx_q == STOP_IDX) begin
                            state_q <= ST_GAP;
                            done_q  <= 1'b1;
                            dat_q   <= 1'b1;
                        end else begin
                            state_q   <= ST_BIT_HI;
                            bit_idx_q <= bit_idx_q + 4'd1;
                            dat_q     <= frame_q[bit_idx_q + 4'd1];
                        end
                    end
                    ST_HOLD: if (!inhibit_i) begin
                        state_q <= ST_GAP;
                        div_q   <= '0;
                    end
                    ST_GAP: if (div_q == GAP_LAST) begin
                        state_q <= ST_IDLE;
                        div_q   <= '0;
                        busy_q  <= 1'b0;
                    end
                    default: div_q <= '0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_dev_tx.sv
// Scoreboard bench for ps2_dev_tx: stimulus pushes expected bytes into a
// queue; a line monitor decodes falling-edge samples and checks each frame.
module tb_ps2_dev_tx;
    localparam int HP = 4, GAP = 8, DEPTH = 4, LW = $clog2(DEPTH) + 1;

    logic          clk = 1'b0, rst = 1'b1;
    logic [7:0]    data = 8'h00;
    logic          valid = 1'b0, inhibit = 1'b0;
    logic          ready, ps2c, ps2d, busy, done;
    logic [LW-1:0] level;

    ps2_dev_tx #(.HALF_PERIOD(HP), .GAP_CYCLES(GAP), .FIFO_DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_i(rst), .data_i(data), .valid_i(valid), .ready_o(ready),
        .inhibit_i(inhibit), .ps2_clk_o(ps2c), .ps2_dat_o(ps2d), .busy_o(busy),
        .done_o(done), .level_o(level)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0]  exp_q[$];
    int          nbits = 0, n_done = 0, n_fall = 0;
    int          first_fall = 0, last_fall = 0, last_done = 0, last_gap = -1;
    bit          after_done = 1'b0;
    logic [10:0] bits = '0, last_frame = '0;
    logic        prev_c = 1'b1, prev_d = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference frame from the protocol rules: start 0, data LSB first,
    // parity making the ones count odd, stop 1.
    function automatic logic [10:0] ref_frame(input logic [7:0] b);
        logic [10:0] f;
        int ones = 0;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            f[i+1] = b[i];
            if (b[i]) ones++;
        end
        f[9]  = (ones % 2 == 0) ? 1'b1 : 1'b0;
        f[10] = 1'b1;
        return f;
    endfunction

    // Line monitor / scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            nbits = 0;
            after_done = 1'b0;
        end else begin
            if (!prev_c && !ps2c) chk("dat_stable_low", ps2d, prev_d);
            if (prev_c && !ps2c) begin
                n_fall++;
                if (nbits == 0 || cyc - last_fall != 2 * HP) begin
                    if (after_done) begin
                        last_gap = cyc - last_done;
                        chk("gap_min", last_gap >= GAP + HP, 1);
                    end
                    after_done = 1'b0;
                    nbits = 0;
                    first_fall = cyc;
                end
                if (nbits < 11) bits[nbits] = ps2d;
                else chk("extra_edge", nbits, 10);
                nbits++;
                last_fall = cyc;
            end
            if (done) begin
                logic [7:0] e;
                chk("done_bits", nbits, 11);
                chk("done_latency", cyc - first_fall, 21 * HP);
                if (exp_q.size() == 0) chk("done_unexpected", exp_q.size(), 1);
                else begin
                    e = exp_q.pop_front();
                    chk("frame", bits, ref_frame(e));
                end
                last_frame = bits;
                n_done++;
                nbits = 0;
                after_done = 1'b1;
                last_done = cyc;
            end
        end
        prev_c = ps2c;
        prev_d = ps2d;
    end

    task automatic push(input logic [7:0] b, input bit acc);
        data  = b;
        valid = 1'b1;
        chk("ready_at_push", ready, acc);
        if (acc) exp_q.push_back(b);
        @(negedge clk);
        valid = 1'b0;
    endtask

    task automatic wait_done(input int prev, input int bound);
        int n = 0;
        while (n_done <= prev && n < bound) begin @(negedge clk); n++; end
        chk("done_wait", n_done, prev + 1);
    endtask

    task automatic wait_idle(input int bound, input bit rnd_inh);
        int n = 0, inh_left = 0;
        while (!(busy == 1'b0 && level == '0 && exp_q.size() == 0 && !inhibit) && n < bound) begin
            if (rnd_inh) begin
                if (inh_left > 0) begin
                    inh_left--;
                    if (inh_left == 0) inhibit = 1'b0;
                end else if ($urandom_range(0, 99) == 0) begin
                    inhibit  = 1'b1;
                    inh_left = $urandom_range(2, 25);
                end
            end
            @(negedge clk);
            n++;
        end
        inhibit = 1'b0;
        chk("idle_wait", 32'(busy) + 32'(level) + exp_q.size(), 0);
    endtask

    task automatic wait_bits(input int k, input int bound);
        int n = 0;
        while (nbits < k && n < bound) begin @(negedge clk); n++; end
        chk("bits_wait", nbits >= k, 1);
        n = 0;
        while (ps2c !== 1'b1 && n < bound) begin @(negedge clk); n++; end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int d0, f0;
        repeat (3) @(negedge clk);
        chk("rst_clk", ps2c, 1);
        chk("rst_dat", ps2d, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_level", level, 0);
        chk("rst_ready", ready, 1);
        rst = 1'b0;
        @(negedge clk);

        // Single byte 0x1C: fixed expected line pattern
        d0 = n_done;
        push(8'h1C, 1'b1);
        wait_done(d0, 300);
        chk("t1_pattern", last_frame, 11'b10000111000);
        wait_idle(300, 1'b0);

        // Back-to-back 0x00, 0xFF: gap between frames
        push(8'h00, 1'b1);
        push(8'hFF, 1'b1);
        wait_idle(600, 1'b0);
        chk("t2_gap", last_gap, GAP + HP);
        chk("t2_parity", last_frame[9], 1);

        // Overfill: five accepted, sixth refused
        for (int i = 0; i < 6; i++) push(8'h30 + 8'(i), i < 5);
        chk("t3_ready_low", ready, 0);
        chk("t3_level_full", level, DEPTH);
        wait_idle(1500, 1'b0);

        // Inhibit during data bit 4 -> abort, then full retransmit
        d0 = n_done;
        push(8'hA5, 1'b1);
        wait_bits(5, 100);
        inhibit = 1'b1;
        @(negedge clk);
        chk("t4_hold_clk", ps2c, 1);
        chk("t4_hold_dat", ps2d, 1);
        chk("t4_hold_busy", busy, 1);
        repeat (20) @(negedge clk);
        chk("t4_no_done", n_done, d0);
        chk("t4_hold_dat2", ps2d, 1);
        inhibit = 1'b0;
        wait_done(d0, 400);
        chk("t4_frame", last_frame, ref_frame(8'hA5));
        wait_idle(300, 1'b0);

        // Inhibit during stop bit -> frame completes, next byte held off
        d0 = n_done;
        push(8'h5A, 1'b1);
        push(8'h33, 1'b1);
        wait_bits(10, 200);
        inhibit = 1'b1;
        wait_done(d0, 100);
        chk("t5_frame", last_frame, ref_frame(8'h5A));
        repeat (40) @(negedge clk);
        chk("t5_busy", busy, 0);
        chk("t5_level", level, 1);
        chk("t5_ndone", n_done, d0 + 1);
        inhibit = 1'b0;
        wait_idle(400, 1'b0);

        // Reset mid-frame
        push(8'h3C, 1'b1);
        push(8'h11, 1'b1);
        wait_bits(4, 100);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        chk("t6_clk", ps2c, 1);
        chk("t6_dat", ps2d, 1);
        chk("t6_level", level, 0);
        chk("t6_ready", ready, 1);
        chk("t6_busy", busy, 0);
        f0 = n_fall;
        d0 = n_done;
        repeat (60) @(negedge clk);
        chk("t6_no_edges", n_fall, f0);
        chk("t6_no_done", n_done, d0);

        // Randomized batches with random host-inhibit pulses
        for (int b = 0; b < 15; b++) begin
            int n = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) begin
                push(8'($urandom), 1'b1);
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
            wait_idle(4000, 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_dev_tx.md
Name: ps2_dev_tx

Overview:
- PS/2 device-side transmitter: emulates a keyboard/mouse that drives clock and data toward the SoC's PS/2 receiver inputs (cust_ps2_ps2_clk, cust_ps2_ps2_dat).
- Used on FPGA boards without a physical PS/2 device, and as a synthesizable stimulus source in SoC-level simulation.
- Bytes are pushed through a valid/ready port into a small FIFO.
- Each byte is serialized as an 11-bit device-to-host frame: start bit, 8 data bits LSB first, odd parity bit, stop bit.

Parameters:
- HALF_PERIOD, 2000: clk_i cycles per PS/2 clock half-period. At 50 MHz this gives 12.5 kHz. Minimum 2.
- GAP_CYCLES, 4000: idle cycles, with clock and data both high, after every frame. Minimum 1.
- FIFO_DEPTH, 4: byte FIFO entries. Power of two, ≥2.

Ports:
- clk_i  in  1  system clock; the only clock.
- rst_i  in  1  synchronous, active-high reset.
- data_i  in  8  byte to transmit.
- valid_i  in  1  data_i valid.
- ready_o  out  1  FIFO not full. Push occurs when valid_i & ready_o.
- inhibit_i  in  1  host-inhibit emulation: holds off or aborts transmission.
- ps2_clk_o  out  1  PS/2 clock toward the host. Idle high.
- ps2_dat_o  out  1  PS/2 data toward the host. Idle high.
- busy_o  out  1  high while a frame, abort wait, or gap is in progress.
- done_o  out  1  one-cycle pulse when a frame's stop bit completes.
- level_o  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.

Behaviour:
- Clocking and reset:
  - Single clock clk_i. rst_i is synchronous and active-high; it overrides all other activity in the same cycle.
  - Reset values: ps2_clk_o=1, ps2_dat_o=1, busy_o=0, done_o=0, level_o=0, ready_o=1. FIFO is emptied; FSM goes to IDLE.
  - A reset mid-frame truncates the frame immediately. Outputs return high on the next cycle and the FIFO content is lost.
- FIFO:
  - ready_o = (level_o != FIFO_DEPTH), combinational from the count.
  - A push while full is ignored.
  - Simultaneous push and pop: level unchanged. Push is still gated by ready_o as it stood before the pop.
- Frame:
  - Frame register bits [10:0] = {1, ~^data, data[7:0], 0}, shifted out from bit 0.
  - The parity bit makes the total number of ones across data plus parity odd.
- FSM states: IDLE, BIT_HI, BIT_LO, HOLD, GAP.
- IDLE:
  - Outputs: clk=1, dat=1, busy_o=0.
  - If the FIFO is not empty and inhibit_i=0: pop, load the frame register, set bit_idx=0, go to BIT_HI.
  - Latency: a byte pushed at cycle t is popped at t+1. ps2_dat_o=0 (start bit) first appears at t+2.
- BIT_HI:
  - ps2_clk_o=1 and ps2_dat_o=frame[bit_idx] for HALF_PERIOD cycles.
  - Data changes only on the first cycle of BIT_HI.
  - Then go to BIT_LO.
- BIT_LO:
  - ps2_clk_o=0 for HALF_PERIOD cycles; data held stable. The host samples on the falling edge with HALF_PERIOD cycles of setup.
  - At the end of the low phase: if bit_idx==10, pulse done_o and go to GAP; otherwise increment bit_idx and go to BIT_HI.
  - Full frame length is 22*HALF_PERIOD cycles.
- GAP:
  - clk=1, dat=1 for GAP_CYCLES cycles, then go to IDLE. busy_o=1.
- Inhibit during a frame:
  - If inhibit_i=1 in BIT_HI or BIT_LO with bit_idx<10: abort and go to HOLD on the next cycle. No done_o pulse.
  - The current byte is retained in the frame register.
  - Once bit_idx==10 (stop bit), inhibit is ignored and the frame completes.
- HOLD:
  - clk=1, dat=1, busy_o=1.
  - When inhibit_i=0, go to GAP. After GAP, the retained byte is retransmitted from the start bit with bit_idx reset, without popping the FIFO.
  - A "retry pending" flag distinguishes this retransmit from a normal IDLE pop.
- Inhibit in IDLE: no pop occurs; outputs stay high.
- Counters:
  - div_cnt width is $clog2(HALF_PERIOD > GAP_CYCLES ? HALF_PERIOD : GAP_CYCLES).
  - div_cnt reloads on every state change.
  - bit_idx is 4 bits.

Decomposition:
- Package ps2_dev_pkg holds:
  - FSM state encoding.
  - FRAME_BITS=11 constant.
  - odd_parity(byte) function.
- Sub-module ps2_tx_fifo: synchronous FIFO parameterized by WIDTH=8 and DEPTH. Ports: push/pop/full/empty/level.
- The top-level holds the FSM, divider, frame register, and retry flag.

Test Plan:
All scenarios use HALF_PERIOD=4 and GAP_CYCLES=8.
1. Push 0x1C after reset → dat sampled at the 11 falling edges = 0,0,0,1,1,1,0,0,0,0,1 (parity 0). done_o pulses once, 88 cycles after the start bit appears.
2. Push 0x00 then 0xFF back-to-back → both frames have parity bit=1. Frame 2's start bit begins exactly GAP_CYCLES=8 cycles after frame 1's stop-bit low phase ends.
3. Push 5 bytes in consecutive cycles with FIFO_DEPTH=4 → 1 is popped, FIFO fills, ready_o drops. All accepted bytes are transmitted in order; no byte is lost or duplicated.
4. Push 0xA5 and assert inhibit_i during data bit 4 → lines return high, no done_o. Release inhibit → after the 8-cycle gap, full 0xA5 frame (parity 1) is resent, then done_o pulses.
5. Assert inhibit_i during the stop bit → frame completes and done_o pulses. With inhibit still high, the next queued byte does not start.
6. Assert rst_i for 1 cycle mid-frame → next cycle: ps2_clk_o=1, ps2_dat_o=1, level_o=0, ready_o=1, busy_o=0. No further edges occur until a new push.
